// File: rtl/aes_req_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_req_scheduler_if
// Brief    : Requester, response and AES-core signals of aes_req_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_req_scheduler_if;
  logic         req0_valid;
  logic         req0_ready;
  logic [127:0] req0_data;
  logic [127:0] req0_key;

  logic         req1_valid;
  logic         req1_ready;
  logic [127:0] req1_data;
  logic [127:0] req1_key;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_id;
  logic         rsp_err;

  logic         core_en;
  logic [127:0] core_data_in;
  logic [127:0] core_key_in;
  logic [127:0] core_data_out;
  logic         core_data_out_valid;

  logic         busy;

  // Environment side: requesters, response consumer and the AES core.
  modport master (
    output req0_valid, req0_data, req0_key,
    input  req0_ready,
    output req1_valid, req1_data, req1_key,
    input  req1_ready,
    input  rsp_valid, rsp_data, rsp_id, rsp_err,
    output rsp_ready,
    input  core_en, core_data_in, core_key_in,
    output core_data_out, core_data_out_valid,
    input  busy
  );

  // Scheduler side.
  modport slave (
    input  req0_valid, req0_data, req0_key,
    output req0_ready,
    input  req1_valid, req1_data, req1_key,
    output req1_ready,
    output rsp_valid, rsp_data, rsp_id, rsp_err,
    input  rsp_ready,
    output core_en, core_data_in, core_key_in,
    input  core_data_out, core_data_out_valid,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/aes_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : aes_req_scheduler
// Brief    : Round-robin two-requester front end launching one block at a time
//            into the AES-128 core, with watchdog timeout and inter-block gap.
// Revision : 1.0 - initial release
// ============================================================================
module aes_req_scheduler #(
  parameter int TIMEOUT    = 64,
  parameter int GAP_CYCLES = 2
) (
  input  logic               AES_clk,
  input  logic               AES_rst,
  aes_req_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam logic [9:0] c_TO_LAST  = 10'(TIMEOUT - 1);
  localparam logic [3:0] c_GAP_LAST = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam bit         c_HAS_GAP  = (GAP_CYCLES > 0);

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_last_grant;
  logic [9:0]   r_to_cnt;
  logic [3:0]   r_gap_cnt;
  logic [127:0] r_core_data_in;
  logic [127:0] r_core_key_in;
  logic [127:0] r_rsp_data;
  logic         r_rsp_id;
  logic         r_rsp_err;

  logic         w_grant;
  logic         w_idle_ok;
  logic         w_req0_rdy;
  logic         w_req1_rdy;
  logic         w_accept;
  logic         w_core_done;
  logic         w_timeout;
  logic         w_rsp_hs;
  logic         w_gap_done;

  // Contention goes to the requester that did not win last time.
  always_comb begin
    w_grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (bus.req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_idle_ok   = (r_state == S_IDLE) && !AES_rst;
  assign w_req0_rdy  = w_idle_ok && bus.req0_valid && !w_grant;
  assign w_req1_rdy  = w_idle_ok && bus.req1_valid && w_grant;
  assign w_accept    = w_req0_rdy || w_req1_rdy;
  assign w_core_done = (r_state == S_BUSY) && bus.core_data_out_valid;
  assign w_timeout   = (r_state == S_BUSY) && (r_to_cnt == c_TO_LAST);
  assign w_rsp_hs    = (r_state == S_RESP) && bus.rsp_ready;
  assign w_gap_done  = (r_state == S_GAP) && (r_gap_cnt == c_GAP_LAST);

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_core_done || w_timeout) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (w_rsp_hs) begin
          w_state_nxt = c_HAS_GAP ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (w_gap_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Both counters restart whenever their state is not active, so they read 0
  // on the first cycle of each BUSY / GAP visit.
  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      r_to_cnt  <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_to_cnt  <= (r_state == S_BUSY) ? (r_to_cnt + 10'd1) : 10'd0;
      r_gap_cnt <= (r_state == S_GAP)  ? (r_gap_cnt + 4'd1) : 4'd0;
    end
  end

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      r_last_grant   <= 1'b1;
      r_core_data_in <= '0;
      r_core_key_in  <= '0;
      r_rsp_data     <= '0;
      r_rsp_id       <= 1'b0;
      r_rsp_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_core_data_in <= w_grant ? bus.req1_data : bus.req0_data;
        r_core_key_in  <= w_grant ? bus.req1_key  : bus.req0_key;
        r_rsp_id       <= w_grant;
        r_last_grant   <= w_grant;
      end
      // A core result in the final watchdog cycle still counts as success.
      if (w_core_done) begin
        r_rsp_data <= bus.core_data_out;
        r_rsp_err  <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b1;
      end
    end
  end

  assign bus.req0_ready   = w_req0_rdy;
  assign bus.req1_ready   = w_req1_rdy;
  assign bus.core_en      = (r_state == S_BUSY);
  assign bus.core_data_in = r_core_data_in;
  assign bus.core_key_in  = r_core_key_in;
  assign bus.rsp_valid    = (r_state == S_RESP);
  assign bus.rsp_data     = r_rsp_data;
  assign bus.rsp_id       = r_rsp_id;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_req_scheduler
// Brief    : Self-checking bench for aes_req_scheduler with a behavioural core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_req_scheduler;
  localparam int TIMEOUT = 64;
  localparam int GAP     = 2;
  localparam logic [127:0] c_FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] c_FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] c_FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst = 1'b1;

  aes_req_scheduler_if bus ();

  aes_req_scheduler #(.TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP)) dut (
    .AES_clk (clk),
    .AES_rst (rst),
    .bus     (bus)
  );

  int n_tests   = 0;
  int n_fail    = 0;
  int stub_lat  = 0;   // BUSY cycle (1-based) on which the core answers; 0 = never
  bit stub_spur = 1'b0;
  int en_cnt    = 0;
  bit model_last = 1'b1;
  logic [127:0] cd [2][4];
  logic [127:0] ck [2][4];

  initial forever #5 clk = ~clk;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Core result: the known AES-128 vector, otherwise a cheap keyed scramble.
  function automatic logic [127:0] stub_fn(input logic [127:0] k, input logic [127:0] d);
    if (k == c_FIPS_KEY && d == c_FIPS_PT) return c_FIPS_CT;
    return {d[63:0], d[127:64]} ^ k ^ 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9669_6996;
  endfunction

  // Cycles from accept to rsp_valid: BUSY lasts until the core answers or the watchdog ends it.
  function automatic int exp_lat(input int lat);
    return ((lat >= 1 && lat <= TIMEOUT) ? lat : TIMEOUT) + 1;
  endfunction

  initial begin
    bus.core_data_out_valid = 1'b0;
    bus.core_data_out       = '0;
    forever begin
      @(negedge clk);
      en_cnt = (bus.core_en === 1'b1) ? en_cnt + 1 : 0;
      if (bus.core_en === 1'b1) begin
        bus.core_data_out_valid = (stub_lat != 0) && (en_cnt == stub_lat);
        bus.core_data_out = bus.core_data_out_valid ? stub_fn(bus.core_key_in, bus.core_data_in)
                                                    : rnd128();
      end else begin
        bus.core_data_out_valid = stub_spur ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.core_data_out       = rnd128();
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Entered at BUSY cycle 1; returns in the first rsp_valid cycle (or after the bound).
  task automatic collect(output int n, output bit en_ok, output bit quiet);
    n = 1; en_ok = 1'b1; quiet = 1'b1;
    while (bus.rsp_valid !== 1'b1 && n < 300) begin
      if (bus.core_en !== 1'b1) en_ok = 1'b0;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) quiet = 1'b0;
      @(negedge clk); #1;
      n++;
    end
  endtask

  // Holds rsp_ready low for `hold` cycles, completes the handshake, then counts GAP cycles.
  task automatic handshake(input int hold, output bit stable, output bit quiet,
                           output int gap_n, output bit gap_ok);
    logic [129:0] snap;
    snap = {bus.rsp_data, bus.rsp_id, bus.rsp_err};
    stable = 1'b1; quiet = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid !== 1'b1 || {bus.rsp_data, bus.rsp_id, bus.rsp_err} !== snap) stable = 1'b0;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) quiet = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    bus.rsp_ready = 1'b0;
    gap_n = 0; gap_ok = 1'b1;
    while (bus.busy === 1'b1 && gap_n < 50) begin
      if (bus.core_en !== 1'b0 || bus.rsp_valid !== 1'b0 ||
          bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) gap_ok = 1'b0;
      gap_n++;
      @(negedge clk); #1;
    end
  endtask

  task automatic drive_reqs(input int p0, input int p1);
    bus.req0_valid = (p0 < 4);
    bus.req0_data  = cd[0][p0 & 3];
    bus.req0_key   = ck[0][p0 & 3];
    bus.req1_valid = (p1 < 4);
    bus.req1_data  = cd[1][p1 & 3];
    bus.req1_key   = ck[1][p1 & 3];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({bus.core_en, bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_err} !== 5'b0)
      begin n_fail++; $display("FAIL reset_ctrl: got %b want 00000",
        {bus.core_en, bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_err}); end
    n_tests++;
    if (bus.core_data_in !== '0 || bus.core_key_in !== '0 || bus.rsp_data !== '0)
      begin n_fail++; $display("FAIL reset_data: got %h/%h/%h want zeros",
        bus.core_data_in, bus.core_key_in, bus.rsp_data); end
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    n_tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00)
      begin n_fail++; $display("FAIL reset_ready: got %b want 00", {bus.req0_ready, bus.req1_ready}); end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    model_last = 1'b1;
  endtask

  task automatic test_single();
    int n, gap_n; bit en_ok, quiet, st, q2, gok;
    stub_lat = 12;
    bus.req0_data = c_FIPS_PT; bus.req0_key = c_FIPS_KEY; bus.req0_valid = 1'b1;
    #1;
    n_tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10)
      begin n_fail++; $display("FAIL single_grant: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
    @(negedge clk); #1;
    model_last = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_data = rnd128(); bus.req0_key = rnd128();
    collect(n, en_ok, quiet);
    n_tests++;
    if (n != exp_lat(12) || !en_ok)
      begin n_fail++; $display("FAIL single_latency: got %0d en_ok=%0d want %0d en_ok=1", n, en_ok, exp_lat(12)); end
    n_tests++;
    if (bus.rsp_data !== c_FIPS_CT || bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0)
      begin n_fail++; $display("FAIL single_rsp: got %h id=%b err=%b want %h id=0 err=0",
        bus.rsp_data, bus.rsp_id, bus.rsp_err, c_FIPS_CT); end
    n_tests++;
    if (bus.core_en !== 1'b0)
      begin n_fail++; $display("FAIL single_en_resp: got %b want 0", bus.core_en); end
    handshake(0, st, q2, gap_n, gok);
    n_tests++;
    if (gap_n != GAP || !gok)
      begin n_fail++; $display("FAIL single_gap: got %0d ok=%0d want %0d ok=1", gap_n, gok, GAP); end
  endtask

  task automatic test_contention();
    int n, gap_n; int p [2]; bit en_ok, quiet, st, q2, gok, exp;
    logic [127:0] expd;
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < 4; j++) begin cd[r][j] = rnd128(); ck[r][j] = rnd128(); end
    p[0] = 0; p[1] = 0;
    stub_lat = 11;
    for (int b = 0; b < 8; b++) begin
      drive_reqs(p[0], p[1]);
      #1;
      exp = (p[0] < 4 && p[1] < 4) ? ~model_last : (p[1] < 4);
      n_tests++;
      if ({bus.req1_ready, bus.req0_ready} !== (exp ? 2'b10 : 2'b01))
        begin n_fail++; $display("FAIL cont_grant[%0d]: got r1r0=%b want id %0d",
          b, {bus.req1_ready, bus.req0_ready}, exp); end
      @(negedge clk); #1;
      model_last = exp;
      expd = stub_fn(ck[exp][p[exp]], cd[exp][p[exp]]);
      p[exp] = p[exp] + 1;
      drive_reqs(p[0], p[1]);
      collect(n, en_ok, quiet);
      n_tests++;
      if (n != exp_lat(11) || !en_ok || !quiet)
        begin n_fail++; $display("FAIL cont_busy[%0d]: got lat %0d en=%0d quiet=%0d want %0d 1 1",
          b, n, en_ok, quiet, exp_lat(11)); end
      n_tests++;
      if (bus.rsp_id !== exp || bus.rsp_data !== expd || bus.rsp_err !== 1'b0)
        begin n_fail++; $display("FAIL cont_rsp[%0d]: got id=%b %h err=%b want id=%b %h err=0",
          b, bus.rsp_id, bus.rsp_data, bus.rsp_err, exp, expd); end
      handshake(int'($urandom_range(0, 3)), st, q2, gap_n, gok);
      n_tests++;
      if (!st || gap_n != GAP || !gok)
        begin n_fail++; $display("FAIL cont_gap[%0d]: got stable=%0d gap=%0d ok=%0d want 1 %0d 1",
          b, st, gap_n, gok, GAP); end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
  endtask

  // Single block from requester `id`; the core answers on BUSY cycle `lat` (0 = never).
  task automatic test_timeout_case(input string tag, input bit id, input int lat);
    int n, gap_n; bit en_ok, quiet, st, q2, gok, err;
    logic [127:0] d, k, expd;
    d = rnd128(); k = rnd128();
    stub_lat = lat;
    err  = !(lat >= 1 && lat <= TIMEOUT);
    expd = err ? 128'd0 : stub_fn(k, d);
    if (id) begin bus.req1_data = d; bus.req1_key = k; bus.req1_valid = 1'b1; end
    else    begin bus.req0_data = d; bus.req0_key = k; bus.req0_valid = 1'b1; end
    #1;
    n_tests++;
    if ({bus.req1_ready, bus.req0_ready} !== (id ? 2'b10 : 2'b01))
      begin n_fail++; $display("FAIL %s_grant: got r1r0=%b want id %0d", tag,
        {bus.req1_ready, bus.req0_ready}, id); end
    @(negedge clk); #1;
    model_last = id;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    collect(n, en_ok, quiet);
    n_tests++;
    if (n != exp_lat(lat) || !en_ok)
      begin n_fail++; $display("FAIL %s_latency: got %0d en_ok=%0d want %0d en_ok=1", tag, n, en_ok, exp_lat(lat)); end
    n_tests++;
    if (bus.rsp_data !== expd || bus.rsp_err !== err || bus.rsp_id !== id || bus.core_en !== 1'b0)
      begin n_fail++; $display("FAIL %s_rsp: got %h err=%b id=%b en=%b want %h err=%b id=%b en=0",
        tag, bus.rsp_data, bus.rsp_err, bus.rsp_id, bus.core_en, expd, err, id); end
    handshake(1, st, q2, gap_n, gok);
  endtask

  task automatic test_backpressure();
    int n, gap_n, lat; bit en_ok, quiet, st, q2, gok;
    logic [127:0] d0, k0, d1, k1;
    lat = int'($urandom_range(3, 20));
    stub_lat = lat;
    d0 = rnd128(); k0 = rnd128(); d1 = rnd128(); k1 = rnd128();
    bus.req0_data = d0; bus.req0_key = k0; bus.req0_valid = 1'b1; bus.req1_valid = 1'b0;
    #1;
    n_tests++;
    if (bus.req0_ready !== 1'b1)
      begin n_fail++; $display("FAIL bp_grant0: got %b want 1", bus.req0_ready); end
    @(negedge clk); #1;
    model_last = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_data = d1; bus.req1_key = k1; bus.req1_valid = 1'b1;
    collect(n, en_ok, quiet);
    n_tests++;
    if (n != exp_lat(lat) || bus.rsp_data !== stub_fn(k0, d0) || bus.rsp_id !== 1'b0 || !quiet)
      begin n_fail++; $display("FAIL bp_rsp0: got lat %0d %h id=%b quiet=%0d want %0d %h id=0 quiet=1",
        n, bus.rsp_data, bus.rsp_id, quiet, exp_lat(lat), stub_fn(k0, d0)); end
    stub_spur = 1'b1;
    handshake(10, st, q2, gap_n, gok);
    stub_spur = 1'b0;
    n_tests++;
    if (!st || !q2)
      begin n_fail++; $display("FAIL bp_hold: got stable=%0d req1_quiet=%0d want 1 1", st, q2); end
    n_tests++;
    if (gap_n != GAP || !gok)
      begin n_fail++; $display("FAIL bp_gap: got %0d ok=%0d want %0d ok=1", gap_n, gok, GAP); end
    n_tests++;
    if (bus.req1_ready !== 1'b1)
      begin n_fail++; $display("FAIL bp_next_accept: got %b want 1", bus.req1_ready); end
    @(negedge clk); #1;
    model_last = 1'b1;
    bus.req1_valid = 1'b0;
    collect(n, en_ok, quiet);
    n_tests++;
    if (n != exp_lat(lat) || bus.rsp_data !== stub_fn(k1, d1) || bus.rsp_id !== 1'b1)
      begin n_fail++; $display("FAIL bp_rsp1: got lat %0d %h id=%b want %0d %h id=1",
        n, bus.rsp_data, bus.rsp_id, exp_lat(lat), stub_fn(k1, d1)); end
    handshake(0, st, q2, gap_n, gok);
  endtask

  task automatic test_reset_busy();
    int n, gap_n, lat; bit en_ok, quiet, st, q2, gok, exp;
    logic [127:0] d0, k0;
    d0 = rnd128(); k0 = rnd128();
    stub_lat = 0;
    bus.req0_data = d0; bus.req0_key = k0; bus.req0_valid = 1'b1; bus.req1_valid = 1'b0;
    @(negedge clk); #1;
    bus.req1_data = rnd128(); bus.req1_key = rnd128(); bus.req1_valid = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    n_tests++;
    if (bus.core_en !== 1'b1 || bus.busy !== 1'b1)
      begin n_fail++; $display("FAIL rb_busy5: got en=%b busy=%b want 1 1", bus.core_en, bus.busy); end
    rst = 1'b1;
    @(negedge clk); #1;
    n_tests++;
    if ({bus.core_en, bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.req0_ready, bus.req1_ready} !== 7'b0 ||
        bus.core_data_in !== '0 || bus.core_key_in !== '0 || bus.rsp_data !== '0)
      begin n_fail++; $display("FAIL rb_reset_vals: got ctl=%b din=%h want all zero",
        {bus.core_en, bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.req0_ready, bus.req1_ready},
        bus.core_data_in); end
    rst = 1'b0;
    model_last = 1'b1;
    #1;
    exp = ~model_last;
    n_tests++;
    if ({bus.req1_ready, bus.req0_ready} !== (exp ? 2'b10 : 2'b01))
      begin n_fail++; $display("FAIL rb_regrant: got r1r0=%b want id %0d", {bus.req1_ready, bus.req0_ready}, exp); end
    lat = int'($urandom_range(2, 10));
    stub_lat = lat;
    @(negedge clk); #1;
    model_last = exp;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    collect(n, en_ok, quiet);
    n_tests++;
    if (n != exp_lat(lat) || bus.rsp_data !== stub_fn(k0, d0) || bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0)
      begin n_fail++; $display("FAIL rb_rsp: got lat %0d %h id=%b err=%b want %0d %h id=0 err=0",
        n, bus.rsp_data, bus.rsp_id, bus.rsp_err, exp_lat(lat), stub_fn(k0, d0)); end
    handshake(0, st, q2, gap_n, gok);
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_key = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_key = '0;
    bus.rsp_ready  = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_timeout_case("timeout", 1'b1, 0);
    test_timeout_case("collision", 1'b0, TIMEOUT);
    test_backpressure();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
